// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - FP issue scheduler steering ops to pipe/div units over a writeback reservation timeline.
// Optional FPU_SCHED_PERF_EN adds saturating perf counters (issued/conflict/stall).
module fpu_issue_sched #(
  parameter int PIPE_LAT = 4,
  parameter int DIV_LAT  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_long,
  input  logic [15:0] req_opid,
  output logic        req_ready,
  output logic        pipe_issue,
  output logic        div_issue,
  output logic        adv,
  input  logic        claim,
  output logic        wb_valid,
  output logic        wb_sel,
  output logic [15:0] wb_opid,
  output logic        div_busy
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_stall
`endif
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic [DIV_LAT-1:0] resv, resv_nxt;
  logic [DIV_LAT-1:0] slot_sel, slot_sel_nxt;
  logic [15:0]        slot_opid     [DIV_LAT];
  logic [15:0]        slot_opid_nxt [DIV_LAT];
  logic [CNT_W-1:0]   div_cnt, div_cnt_nxt;
  logic               pipe_slot_busy;

  // A short op lands in slot PIPE_LAT-1 after the shift, i.e. today's slot PIPE_LAT.
  generate
    if (PIPE_LAT < DIV_LAT) begin : g_pipe_slot
      assign pipe_slot_busy = resv[PIPE_LAT];
    end else begin : g_no_pipe_slot
      assign pipe_slot_busy = 1'b0;
    end
  endgenerate

  assign adv        = ~resv[0] | claim;
  assign pipe_issue = req_valid & ~req_long & adv & ~flush & ~pipe_slot_busy;
  assign div_issue  = req_valid & req_long & adv & ~flush & (div_cnt == '0);
  assign req_ready  = pipe_issue | div_issue;
  assign div_busy   = (div_cnt != '0);
  assign wb_valid   = resv[0];
  assign wb_sel     = resv[0] & slot_sel[0];
  assign wb_opid    = resv[0] ? slot_opid[0] : 16'h0000;

  always_comb begin
    resv_nxt      = resv;
    slot_sel_nxt  = slot_sel;
    slot_opid_nxt = slot_opid;
    div_cnt_nxt   = div_cnt;
    if (adv) begin
      resv_nxt     = {1'b0, resv[DIV_LAT-1:1]};
      slot_sel_nxt = {1'b0, slot_sel[DIV_LAT-1:1]};
      for (int k = 0; k < DIV_LAT - 1; k++) begin
        slot_opid_nxt[k] = slot_opid[k+1];
      end
      slot_opid_nxt[DIV_LAT-1] = 16'h0000;
      if (div_cnt != '0) begin
        div_cnt_nxt = div_cnt - CNT_W'(1);
      end
    end
    if (pipe_issue) begin
      resv_nxt[PIPE_LAT-1]      = 1'b1;
      slot_sel_nxt[PIPE_LAT-1]  = 1'b0;
      slot_opid_nxt[PIPE_LAT-1] = req_opid;
    end
    if (div_issue) begin
      resv_nxt[DIV_LAT-1]      = 1'b1;
      slot_sel_nxt[DIV_LAT-1]  = 1'b1;
      slot_opid_nxt[DIV_LAT-1] = req_opid;
      div_cnt_nxt              = CNT_W'(DIV_LAT);
    end
  end

  // Flush clears regardless of adv, so a stalled response cannot block it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv     <= '0;
      slot_sel <= '0;
      div_cnt  <= '0;
      for (int k = 0; k < DIV_LAT; k++) begin
        slot_opid[k] <= 16'h0000;
      end
    end else if (flush) begin
      resv     <= '0;
      slot_sel <= '0;
      div_cnt  <= '0;
      for (int k = 0; k < DIV_LAT; k++) begin
        slot_opid[k] <= 16'h0000;
      end
    end else begin
      resv      <= resv_nxt;
      slot_sel  <= slot_sel_nxt;
      div_cnt   <= div_cnt_nxt;
      slot_opid <= slot_opid_nxt;
    end
  end

`ifdef FPU_SCHED_PERF_EN
  // Counters survive flush so a run can be profiled across pipeline restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued   <= '0;
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      if (req_ready && (perf_issued != 32'hFFFF_FFFF)) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (req_valid && adv && !req_ready && (perf_conflict != 32'hFFFF_FFFF)) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
      if (!adv && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb/tb_fpu_issue_sched.sv - scoreboard bench for fpu_issue_sched with a virtual-time reference model.
module tb_fpu_issue_sched;

  localparam int PIPE_LAT = 4;
  localparam int DIV_LAT  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_long;
  logic [15:0] req_opid;
  logic        req_ready;
  logic        pipe_issue;
  logic        div_issue;
  logic        adv;
  logic        claim;
  logic        wb_valid;
  logic        wb_sel;
  logic [15:0] wb_opid;
  logic        div_busy;
`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_conflict;
  logic [31:0] perf_stall;
`endif

  fpu_issue_sched #(.PIPE_LAT(PIPE_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_long   (req_long),
    .req_opid   (req_opid),
    .req_ready  (req_ready),
    .pipe_issue (pipe_issue),
    .div_issue  (div_issue),
    .adv        (adv),
    .claim      (claim),
    .wb_valid   (wb_valid),
    .wb_sel     (wb_sel),
    .wb_opid    (wb_opid),
    .div_busy   (div_busy)
`ifdef FPU_SCHED_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_conflict (perf_conflict),
    .perf_stall    (perf_stall)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: time counts only advancing cycles; a result is due at issue_time + latency.
  typedef struct {
    logic [15:0] opid;
    logic        sel;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  bit   pend[int];
  int   vt          = 0;
  int   last_long   = 0;
  bit   long_valid  = 1'b0;
  int   wb_cycle[logic [15:0]];

  // Monitor: every consumed response is matched against the earliest-due expectation.
  int   mi;
  exp_t e;
  always @(negedge clk) begin
    if (wb_valid !== 1'b1 && wb_opid !== 16'h0000) begin
      check("wb_opid_idle_zero", {16'h0, wb_opid}, 32'h0);
    end
    if (wb_valid === 1'b1 && claim === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", {16'h0, wb_opid}, 32'h0);
      end else begin
        mi = 0;
        for (int i = 1; i < exp_q.size(); i++) begin
          if (exp_q[i].due < exp_q[mi].due) mi = i;
        end
        e = exp_q[mi];
        exp_q.delete(mi);
        check("sb_opid", {16'h0, wb_opid}, {16'h0, e.opid});
        check("sb_sel", {31'h0, wb_sel}, {31'h0, e.sel});
        wb_cycle[wb_opid] = cyc;
      end
    end
  end

  function automatic int seen(input logic [15:0] id);
    return wb_cycle.exists(id) ? (wb_cycle[id] - base) : -1;
  endfunction

  task automatic cycle(input logic v, input logic lng, input logic [15:0] id,
                       input logic fl, input logic cl);
    logic ewb, eadv, ebusy, eshort_ok, epipe, ediv;
    req_valid = v;
    req_long  = lng;
    req_opid  = id;
    flush     = fl;
    claim     = cl;
    #2;
    ewb       = pend.exists(vt);
    eadv      = !ewb || cl;
    ebusy     = long_valid && ((vt - last_long) <= DIV_LAT);
    eshort_ok = !pend.exists(vt + PIPE_LAT);
    epipe     = v && !lng && eadv && !fl && eshort_ok;
    ediv      = v && lng && eadv && !fl && !ebusy;
    check("wb_valid", {31'h0, wb_valid}, {31'h0, ewb});
    check("adv", {31'h0, adv}, {31'h0, eadv});
    check("div_busy", {31'h0, div_busy}, {31'h0, ebusy});
    check("pipe_issue", {31'h0, pipe_issue}, {31'h0, epipe});
    check("div_issue", {31'h0, div_issue}, {31'h0, ediv});
    check("req_ready", {31'h0, req_ready}, {31'h0, epipe | ediv});
    @(negedge clk);
    #1;
    if (fl) begin
      pend.delete();
      exp_q.delete();
      long_valid = 1'b0;
    end else if (eadv) begin
      if (ewb) pend.delete(vt);
      if (epipe) begin
        pend[vt + PIPE_LAT] = 1'b1;
        exp_q.push_back('{id, 1'b0, vt + PIPE_LAT});
      end
      if (ediv) begin
        pend[vt + DIV_LAT] = 1'b1;
        exp_q.push_back('{id, 1'b1, vt + DIV_LAT});
        last_long  = vt;
        long_valid = 1'b1;
      end
      vt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic cl);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b0, cl);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h0);
    check({tag, "_pipe_issue"}, {31'h0, pipe_issue}, 32'h0);
    check({tag, "_div_issue"}, {31'h0, div_issue}, 32'h0);
    check({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'h0);
    check({tag, "_wb_sel"}, {31'h0, wb_sel}, 32'h0);
    check({tag, "_div_busy"}, {31'h0, div_busy}, 32'h0);
    check({tag, "_wb_opid"}, {16'h0, wb_opid}, 32'h0);
    check({tag, "_adv"}, {31'h0, adv}, 32'h1);
  endtask

  task automatic reset_pulse();
    req_valid = 1'b0;
    req_long  = 1'b0;
    req_opid  = 16'h0000;
    flush     = 1'b0;
    claim     = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_values("async_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    pend.delete();
    exp_q.delete();
    long_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rid;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_long  = 1'b0;
    req_opid  = 16'h0000;
    claim     = 1'b0;
    #2 check_reset_values("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Long op, then a short op whose slot collides with it.
    base = cyc;
    cycle(1'b1, 1'b1, 16'h8010, 1'b0, 1'b1);
    idle(7, 1'b1);
    cycle(1'b1, 1'b0, 16'h8011, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 16'h8011, 1'b0, 1'b1);
    idle(DIV_LAT + 4, 1'b1);
    check("lts_8010_cycle", seen(16'h8010), 12);
    check("lts_8011_cycle", seen(16'h8011), 13);
`ifdef FPU_SCHED_PERF_EN
    check("perf_issued", perf_issued, 32'd2);
    check("perf_conflict", perf_conflict, 32'd1);
    check("perf_stall", perf_stall, 32'd0);
`endif

    // Back-to-back short ops.
    base = cyc;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h8001 + 16'(i), 1'b0, 1'b1);
    idle(8, 1'b1);
    for (int i = 0; i < 5; i++) check("b2b_cycle", seen(16'h8001 + 16'(i)), 4 + i);

    // Two long ops in a row; the second waits for the divider.
    base = cyc;
    cycle(1'b1, 1'b1, 16'h8020, 1'b0, 1'b1);
    for (int i = 1; i <= 13; i++) cycle(1'b1, 1'b1, 16'h8021, 1'b0, 1'b1);
    idle(DIV_LAT + 2, 1'b1);
    check("ll_8020_cycle", seen(16'h8020), 12);
    check("ll_8021_cycle", seen(16'h8021), 25);

    // Unclaimed result stretches everything behind it.
    base = cyc;
    cycle(1'b1, 1'b0, 16'h8030, 1'b0, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 1'b0, 16'h8031, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);
    check("stall_8030_cycle", seen(16'h8030), 7);
    check("stall_8031_cycle", seen(16'h8031), 10);

    // Flush with a long op pending and a request in the flush cycle.
    base = cyc;
    cycle(1'b1, 1'b1, 16'h8040, 1'b0, 1'b1);
    idle(1, 1'b1);
    cycle(1'b1, 1'b0, 16'h8041, 1'b1, 1'b1);
    check("flush_div_busy", {31'h0, div_busy}, 32'h0);
    check("flush_wb_valid", {31'h0, wb_valid}, 32'h0);
    idle(DIV_LAT + 2, 1'b1);
    check("flush_8040_dropped", seen(16'h8040), -1);
    check("flush_8041_dropped", seen(16'h8041), -1);

    // Asynchronous reset mid-operation.
    cycle(1'b1, 1'b1, 16'h8050, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 16'h8051, 1'b0, 1'b1);
    idle(PIPE_LAT, 1'b0);
    reset_pulse();
    base = cyc;
    cycle(1'b1, 1'b0, 16'h8052, 1'b0, 1'b1);
    idle(DIV_LAT + 2, 1'b1);
    check("rst_8050_dropped", wb_cycle.exists(16'h8050) ? 32'h1 : 32'h0, 32'h0);
    check("rst_8051_dropped", wb_cycle.exists(16'h8051) ? 32'h1 : 32'h0, 32'h0);
    check("rst_8052_cycle", seen(16'h8052), 4);

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      rid = {1'b1, 15'($urandom)};
      cycle(($urandom % 4) != 0, ($urandom % 5) == 0, rid,
            ($urandom % 60) == 0, ($urandom % 4) != 0);
    end
    idle(DIV_LAT + 4, 1'b1);
    check("sb_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Issue scheduler for the floating-point execution cluster: admits one FP operation per cycle from the FPU register-read buffer and steers it to either the fixed-latency pipelined FP datapath (add/mul/cmp/cvt/…) or the unpipelined fixed-latency divide/sqrt unit. It keeps a writeback reservation timeline so the two units never collide on the single FPU response port. It also gates the whole cluster while a completed result waits for the downstream claim.

## Interface
Parameters:
- `PIPE_LAT`, 4: latency of the pipelined datapath, issue to writeback; 1 ≤ PIPE_LAT < DIV_LAT.
- `DIV_LAT`, 12: latency of the divide/sqrt unit, issue to writeback; ≤ 32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous pipeline flush.
- `req_valid`  in  1  head-of-buffer FP op present.
- `req_long`  in  1  op is FDIV/FSQRT (long unit).
- `req_opid`  in  16  op id; bit 15 is the valid marker.
- `req_ready`  out  1  head op accepted this cycle.
- `pipe_issue`  out  1  start op in pipelined datapath.
- `div_issue`  out  1  start op in divide/sqrt unit.
- `adv`  out  1  cluster advance enable; datapath and divider hold state when low.
- `claim`  in  1  downstream consumed the current response.
- `wb_valid`  out  1  a result is at the response port.
- `wb_sel`  out  1  result source: 0 = pipelined datapath, 1 = div/sqrt.
- `wb_opid`  out  16  opid of the result; 0 when `wb_valid` is low.
- `div_busy`  out  1  divide/sqrt unit occupied.

## Operation
- State:
  - reservation vector `resv[DIV_LAT-1:0]`, one bit per future writeback slot; slot 0 is the current cycle;
  - per-slot opid array and source bit;
  - divider down-counter `div_cnt`, width clog2(DIV_LAT+1).
- Advance: `adv = ~resv[0] | claim`.
  - When `adv` is low, no state changes, except that flush still clears.
  - `req_ready` is low while `adv` is low.
- On advance, all slots shift down by one (slot k → slot k-1).
- Short issue:
  - condition: `req_valid & ~req_long & adv & ~flush & ~resv[PIPE_LAT]`;
  - `resv[PIPE_LAT]` reads as 0 when PIPE_LAT = DIV_LAT;
  - effect: sets slot PIPE_LAT-1 after the shift, with opid and sel=0.
- Long issue:
  - condition: `req_valid & req_long & adv & ~flush & div_cnt==0`;
  - effect: sets slot DIV_LAT-1 with sel=1 and loads `div_cnt = DIV_LAT`;
  - `div_cnt` decrements by 1 on each advance while nonzero.
- `div_busy = div_cnt != 0`.
- `req_ready = pipe_issue | div_issue`; at most one issue per cycle; in-order, no bypass of a blocked head.
- Writeback:
  - `wb_valid = resv[0]`; `wb_sel` and `wb_opid` come from slot 0;
  - the slot clears when it shifts out on advance, i.e. when claimed.
- Flush: clears `resv`, opids and `div_cnt` at the next edge; no issue in the flush cycle; outputs are low the following cycle.
- Reset: same clear as flush, applied asynchronously.

## Timing
- Reset values:
  - `req_ready`, `pipe_issue`, `div_issue`, `wb_valid`, `wb_sel`, `div_busy` = 0;
  - `wb_opid` = 0;
  - `adv` = 1.
- Short op issued in cycle t, with all cycles advancing: `wb_valid` high in cycle t+PIPE_LAT.
- Long op issued in cycle t: `wb_valid` high in cycle t+DIV_LAT; next long issue is allowed earliest at t+DIV_LAT+1.
- Back-to-back short ops sustain 1 op/cycle.
- A short op is blocked for exactly the cycle in which its writeback slot equals a pending long op's slot; it issues the next cycle.
- Stall: if `wb_valid & ~claim` for n cycles, all latencies stretch by n and no slot is lost or duplicated.
- Flush and a valid request in the same cycle: the flush wins and the request is not accepted.
- Reset asserted mid-operation: all pending results are dropped; the first legal issue is in the cycle after `rst` deasserts.

## Configuration
- `FPU_SCHED_PERF_EN`: when defined, adds 32-bit saturating counters plus their outputs:
  - `perf_issued`: counts accepted ops;
  - `perf_conflict`: counts cycles with `req_valid & adv & ~req_ready`;
  - `perf_stall`: counts cycles with `adv` low.
- The counters reset only on `rst`, not on `flush`.
- When the macro is undefined, the counters and their ports are absent; all other behaviour is identical.

## Test plan
All scenarios use PIPE_LAT=4, DIV_LAT=12 unless stated.
- Back-to-back short ops: short ops opid 0x8001..0x8005 issued in cycles 0..4 with `claim`=1 → `wb_opid` 0x8001..0x8005 in cycles 4..8, with `wb_sel`=0.
- Long op then competing short op: long 0x8010 issued in cycle 0; short 0x8011 presented in cycle 8 → 0x8011 stalls in cycle 8 (`req_ready`=0) and issues in cycle 9; 0x8010 writes back in cycle 12 and 0x8011 in cycle 13.
- Two long ops in a row: longs 0x8020 and 0x8021 presented from cycle 0 → second issue in cycle 13; `div_busy` high in cycles 1..12.
- Unclaimed result: short 0x8030 issued in cycle 0 with `claim` low in cycles 4..6 → `adv`=0 in cycles 4..6; `wb_opid`=0x8030 held until cycle 7; a short issued in cycle 3 appears in cycle 10.
- Flush and reset: flush in cycle 2 with a long op pending → `div_busy`=0 and `wb_valid`=0 from cycle 3, and a request in cycle 2 is not accepted; async `rst` pulse mid-cycle → all outputs at their reset values immediately.
- With `FPU_SCHED_PERF_EN`: rerun the long-then-short scenario → `perf_issued`=2, `perf_conflict`=1.
